cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
Two-stage pipelined 16-bit add/subtract unit with valid/ready handshakes on input and output.
Stage 1 registers per-bit generate/propagate signals and the carry-in. Stage 2 resolves carries with two-level 4-bit-group lookahead (4 group units plus 1 block unit), then registers the sum and flags.
Sits between the operand-select logic and the result writeback in the ALU datapath.

Parameters:
WIDTH, 16, operand width; fixed at 16 (4 groups of 4 bits); other values are unsupported.
GROUP, 4, bits per lookahead group.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  stage 1 can accept this cycle
a  input  16  operand A
b  input  16  operand B
cin  input  1  carry-in (ignored when sub=1)
sub  input  1  1 = compute a - b
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
sum  output  16  result
cout  output  1  carry out of bit 15 (in subtract mode, 1 = no borrow)
ovf  output  1  signed overflow
zero  output  1  sum == 0

Behaviour:
- Reset (async assert, sync deassert):
  - s1_valid = 0, out_valid = 0.
  - sum, cout, ovf, zero = 0.
  - All stage-1 data registers = 0.
- Operand conditioning:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Stage 1:
  - Per bit i: g[i] = a[i] & b_eff[i]; p[i] = a[i] ^ b_eff[i].
  - Register g, p, c0; set s1_valid.
- Stage 2, group level:
  - Each group k computes c[4k+1..4k+4] from its g/p and its group carry-in.
  - Each group also computes group G_k = g3 | p3g2 | p3p2g1 | p3p2p1g0 and P_k = p3&p2&p1&p0.
- Stage 2, block level:
  - Block unit computes group carry-ins C4, C8, C12 from G_k, P_k and c0.
  - C16 = cout.
- Stage 2, outputs:
  - sum[i] = p[i] ^ c[i].
  - ovf = c[15] ^ c[16].
  - zero = (sum == 0).
  - All four outputs are registered together; set out_valid.
- Handshake:
  - adv2 = !out_valid | out_ready.
  - in_ready = !s1_valid | adv2.
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Stage 2 loads when s1_valid & adv2; otherwise out_valid clears on transfer.
  - s1_valid next = (in_valid & in_ready) | (s1_valid & !adv2).
- Latency and throughput:
  - Exactly 2 cycles from input transfer to out_valid, with no stall.
  - Sustains 1 result per cycle while out_ready = 1.
- Stall:
  - out_valid=1 and out_ready=0: sum and flags hold stable and stage 2 does not load.
  - Stage 1 holds its contents; in_ready = 0 once s1_valid = 1.
- Simultaneous events:
  - Same-cycle output transfer plus stage-1 advance plus new input is legal; no bubble is inserted.
- Data ordering: no reordering, no drop, no duplication.
- in_valid=0 for a cycle: a bubble propagates and out_valid deasserts for one cycle.
- Reset mid-operation: in-flight data is discarded and both valids clear immediately.
- Inputs are sampled only on a transfer; a and b may change freely otherwise.
- X on a, b, cin or sub while in_valid=0 must not propagate to any output.

Decomposition:
- Package cla_pkg:
  - Constants: WIDTH=16, GROUP=4, NGROUPS=4.
  - Typedefs: word_t (16 bits), gp_t (struct of g and p words plus c0), result_t (sum, cout, ovf, zero).
- One sub-module, cla_group4:
  - Inputs: 4-bit g/p slice and a group carry-in.
  - Outputs: 4 carries plus group G/P.
  - Instantiated 4 times at group level; its G/P equations are reused in the block-level unit.
- Pipeline control stays in the top module.

Test Plan:
1. Ripple-through carry:
   - a=0xFFFF, b=0x0001, cin=0, sub=0.
   - After 2 cycles: sum=0x0000, cout=1, ovf=0, zero=1.
2. Signed overflow and subtract:
   - a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0.
   - a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
3. Back-to-back throughput:
   - 8 consecutive adds i+i for i=1..8, out_ready held 1.
   - Results 2,4,...,16 on 8 consecutive cycles starting 2 cycles after the first input.
4. Backpressure:
   - out_ready=0 for 5 cycles with a 3-op stream.
   - in_ready drops once both stages are full; the first result holds stable.
   - On release, all 3 results emerge in order with none lost or duplicated.
5. Reset mid-flight:
   - Assert rst_n=0 with both stages valid.
   - out_valid=0 and sum=0 immediately (async); no stale result appears after deassert.
6. Random cross-check:
   - 10k random a, b, cin, sub with random out_ready.
   - Every result matches the reference model {cout,sum} = a + b_eff + c0, with ovf and zero flags correct.

Source files
------------

// File: rtl/cla_pipe_adder_pkg.sv
// Shared types and lookahead equations for the pipelined 16-bit CLA add/subtract unit.
package cla_pkg;

    localparam int WIDTH   = 16;
    localparam int GROUP   = 4;
    localparam int NGROUPS = WIDTH / GROUP;

    typedef logic [WIDTH-1:0] word_t;

    typedef struct packed {
        word_t g;
        word_t p;
        logic  c0;
    } gp_t;

    typedef struct packed {
        word_t sum;
        logic  cout;
        logic  ovf;
        logic  zero;
    } result_t;

    // Flattened 4-bit lookahead: carries out of bits 0..3 given a carry-in.
    function automatic logic [3:0] lookaheadCarries(input logic [3:0] g, input logic [3:0] p,
                                                    input logic c);
        logic [3:0] carry;
        carry[0] = g[0] | (p[0] & c);
        carry[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        carry[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        carry[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c);
        return carry;
    endfunction

    // Group generate/propagate, returned as {G, P}.
    function automatic logic [1:0] groupGenProp(input logic [3:0] g, input logic [3:0] p);
        logic gg;
        logic pg;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pg = &p;
        return {gg, pg};
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle; master is the operand producer and result consumer.
interface cla_pipe_adder_if;
    import cla_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t a;
    word_t b;
    logic  cin;
    logic  sub;
    logic  out_valid;
    logic  out_ready;
    word_t sum;
    logic  cout;
    logic  ovf;
    logic  zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface

// File: rtl/cla_pipe_adder_group4.sv
// One 4-bit lookahead group: internal carries plus group generate/propagate.
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP-1:0] g_i,
    input  logic [GROUP-1:0] p_i,
    input  logic             c_i,
    output logic [GROUP-1:0] c_o,
    output logic             g_o,
    output logic             p_o
);

    assign c_o        = lookaheadCarries(g_i, p_i, c_i);
    assign {g_o, p_o} = groupGenProp(g_i, p_i);

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage add/subtract: stage 1 registers bitwise g/p, stage 2 resolves carries
// with two-level lookahead and registers sum and flags.
module cla_pipe_adder
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    cla_pipe_adder_if.slave  bus
);

    gp_t     s1Q;
    gp_t     s1D;
    logic    s1ValidQ;
    logic    s1ValidD;
    result_t resQ;
    result_t resD;
    logic    outValidQ;
    logic    outValidD;

    logic    adv2;
    logic    inReady;
    logic    inXfer;
    logic    load2;
    word_t   bEff;
    logic    c0In;

    logic [NGROUPS-1:0] grpG;
    logic [NGROUPS-1:0] grpP;
    logic [NGROUPS-1:0] grpCin;
    logic [NGROUPS-1:0] blkCarry;
    logic [WIDTH:1]     grpCarry;
    word_t              carryVec;
    word_t              sumVec;

    assign adv2    = !outValidQ || bus.out_ready;
    assign inReady = !s1ValidQ || adv2;
    assign inXfer  = bus.in_valid && inReady;
    assign load2   = s1ValidQ && adv2;

    // Operands are only looked at on a transfer, so idle-cycle X never reaches state.
    assign bEff = bus.sub ? ~bus.b : bus.b;
    assign c0In = bus.sub ? 1'b1 : bus.cin;

    always_comb begin
        s1D      = s1Q;
        s1ValidD = inXfer || (s1ValidQ && !adv2);
        if (inXfer) begin
            s1D.g  = bus.a & bEff;
            s1D.p  = bus.a ^ bEff;
            s1D.c0 = c0In;
        end
    end

    assign blkCarry = lookaheadCarries(grpG, grpP, s1Q.c0);
    assign grpCin   = {blkCarry[NGROUPS-2:0], s1Q.c0};

    for (genvar k = 0; k < NGROUPS; k++) begin : gGroup
        cla_group4 uGroup (
            .g_i (s1Q.g[k*GROUP +: GROUP]),
            .p_i (s1Q.p[k*GROUP +: GROUP]),
            .c_i (grpCin[k]),
            .c_o (grpCarry[k*GROUP+1 +: GROUP]),
            .g_o (grpG[k]),
            .p_o (grpP[k])
        );
    end

    assign carryVec = {grpCarry[WIDTH-1:1], s1Q.c0};
    assign sumVec   = s1Q.p ^ carryVec;

    always_comb begin
        resD      = resQ;
        outValidD = outValidQ;
        if (load2) begin
            resD.sum  = sumVec;
            resD.cout = blkCarry[NGROUPS-1];
            resD.ovf  = grpCarry[WIDTH-1] ^ grpCarry[WIDTH];
            resD.zero = (sumVec == '0);
            outValidD = 1'b1;
        end else if (outValidQ && bus.out_ready) begin
            outValidD = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Q       <= '0;
            s1ValidQ  <= 1'b0;
            resQ      <= '0;
            outValidQ <= 1'b0;
        end else begin
            s1Q       <= s1D;
            s1ValidQ  <= s1ValidD;
            resQ      <= resD;
            outValidQ <= outValidD;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValidQ;
    assign bus.sum       = resQ.sum;
    assign bus.cout      = resQ.cout;
    assign bus.ovf       = resQ.ovf;
    assign bus.zero      = resQ.zero;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and random checks of cla_pipe_adder against a behavioural add/subtract model.
module tb_cla_pipe_adder;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    int   acceptedCount;
    int   acceptBase;

    logic [18:0] expQ[$];

    cla_pipe_adder_if bus();

    cla_pipe_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {sum, cout, ovf, zero} from plain wide arithmetic.
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
        logic [15:0] be;
        logic        c0;
        logic [16:0] r;
        logic        ov;
        be = sub ? ~b : b;
        c0 = sub ? 1'b1 : cin;
        r  = {1'b0, a} + {1'b0, be} + {16'b0, c0};
        ov = (a[15] == be[15]) && (r[15] != a[15]);
        return {r[15:0], r[16], ov, (r[15:0] == 16'h0000)};
    endfunction

    function automatic logic [31:0] obs();
        return {13'b0, bus.sum, bus.cout, bus.ovf, bus.zero};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then score any transfer the next rising edge will take.
    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, input logic rdy);
        @(negedge clk);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.sub       = sub;
        bus.out_ready = rdy;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0)
                checkOutput("spurious_out", 32'(bus.out_valid), 32'd0);
            else
                checkOutput("scoreboard", obs(), {13'b0, expQ.pop_front()});
        end
        if (bus.in_valid && bus.in_ready) begin
            expQ.push_back(model(a, b, cin, sub));
            acceptedCount++;
        end
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        acceptedCount = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_result", obs(), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        // Full-width carry ripple, result two cycles after transfer
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_gap", 32'(bus.out_valid), 32'd0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("t1_result", obs(), {13'b0, 16'h0000, 1'b1, 1'b0, 1'b1});

        // Signed overflow, then subtract with cin set (must be ignored)
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_ovf", obs(), {13'b0, 16'h8000, 1'b0, 1'b1, 1'b0});
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_sub", obs(), {13'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0});
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t2_drain", 32'(bus.out_valid), 32'd0);

        // Back-to-back i+i, one result per cycle
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8)
                applyStimulus(1'b1, 16'(i), 16'(i), 1'b0, 1'b0, 1'b1);
            else
                applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            if (i >= 3) begin
                checkOutput("t3_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("t3_sum", 32'(bus.sum), 32'(2 * (i - 2)));
            end
        end
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t3_drain", 32'(bus.out_valid), 32'd0);

        // Backpressure: 5 cycles of out_ready=0 against a 3-op stream
        applyStimulus(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h1000, 16'h0001, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 16'hABCD, 16'h1234, 1'b0, 1'b0, 1'b0);
            checkOutput("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
            checkOutput("t4_hold", obs(), {13'b0, 16'h3333, 1'b0, 1'b0, 1'b0});
        end
        applyStimulus(1'b1, 16'hABCD, 16'h1234, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_release_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_second", obs(), {13'b0, 16'h0FFF, 1'b1, 1'b0, 1'b0});
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_third", obs(), {13'b0, 16'hBE01, 1'b0, 1'b0, 1'b0});
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_drain", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset with both stages occupied
        applyStimulus(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h2222, 16'h1111, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("t5_full_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("t5_full_ready", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("t5_async_sum", 32'(bus.sum), 32'd0);
        checkOutput("t5_async_ready", 32'(bus.in_ready), 32'd1);
        expQ.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            checkOutput("t5_no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Random operands, random valid and random backpressure
        acceptBase = acceptedCount;
        for (int cyc = 0; cyc < 60000 && (acceptedCount - acceptBase) < 10000; cyc++) begin
            logic v;
            logic rdy;
            v   = ($urandom_range(3) != 0);
            rdy = ($urandom_range(1) != 0);
            if (v)
                applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), rdy);
            else
                applyStimulus(1'b0, 16'hxxxx, 16'hxxxx, 1'bx, 1'bx, rdy);
        end
        checkOutput("t6_accepted", 32'(acceptedCount - acceptBase), 32'd10000);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        checkOutput("t6_all_drained", 32'(expQ.size()), 32'd0);
        checkOutput("t6_idle_valid", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
